// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-requester round-robin bus arbiter with tenure limit; in clock/reset/req_x/muxIn_x, out grant_x/sel/enable/busOut/busValid/holdCount
module bus_arbiter_2 #(
  parameter int nrOfBits = 8,
  parameter int maxHold  = 4,
  parameter int cntBits  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_0,
  input  logic                req_1,
  input  logic [nrOfBits-1:0] muxIn_0,
  input  logic [nrOfBits-1:0] muxIn_1,
  output logic                grant_0,
  output logic                grant_1,
  output logic                sel,
  output logic                enable,
  output logic [nrOfBits-1:0] busOut,
  output logic                busValid,
  output logic [cntBits-1:0]  holdCount
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [cntBits-1:0] HOLD_MAX = cntBits'(maxHold - 1);
  state_t state_q, state_d, other;
  logic last_q, last_d, own_req, oth_req;
  logic [cntBits-1:0] hold_q, hold_d;
  logic [nrOfBits-1:0] bus_q, bus_d;
  logic valid_q, valid_d;
  always_comb begin
    own_req = (state_q == GRANT1) ? req_1 : req_0;
    oth_req = (state_q == GRANT1) ? req_0 : req_1;
    other   = (state_q == GRANT0) ? GRANT1 : GRANT0;
    state_d = (state_q == IDLE) ? ((req_0 && req_1) ? (last_q ? GRANT0 : GRANT1) :
                                   req_0 ? GRANT0 : req_1 ? GRANT1 : IDLE) :
              !own_req ? (oth_req ? other : IDLE) :
              (oth_req && hold_q == HOLD_MAX) ? other : state_q;
    hold_d  = (state_d == IDLE || state_d != state_q) ? '0 :
              (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    last_d  = (state_d == GRANT0) ? 1'b0 : (state_d == GRANT1) ? 1'b1 : last_q;
    bus_d   = enable ? (sel ? muxIn_1 : muxIn_0) : '0;
    valid_d = enable;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
    end
  end
  assign grant_0   = (state_q == GRANT0);
  assign grant_1   = (state_q == GRANT1);
  assign sel       = grant_1;
  assign enable    = grant_0 | grant_1;
  assign busOut    = bus_q;
  assign busValid  = valid_q;
  assign holdCount = hold_q;
endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb_bus_arbiter_2: randomized and directed checks of bus_arbiter_2 (maxHold 4 and 1) against a behavioural model
module tb_bus_arbiter_2;
  logic clk = 0, rst = 1, r0 = 0, r1 = 0;
  logic [7:0] m0 = 0, m1 = 0;
  logic g0a, g1a, sela, ena, va, g0b, g1b, selb, enb, vb;
  logic [7:0] ba, bb;
  logic [2:0] ha, hb;
  int n_cmp = 0, n_bad = 0;
  int m_own[2], m_last[2], m_ten[2];
  logic [7:0] m_bus[2];
  logic m_val[2];
  always #5 clk = ~clk;
  bus_arbiter_2 #(.nrOfBits(8), .maxHold(4), .cntBits(3)) dut_a (
    .clock(clk), .reset(rst), .req_0(r0), .req_1(r1), .muxIn_0(m0), .muxIn_1(m1),
    .grant_0(g0a), .grant_1(g1a), .sel(sela), .enable(ena), .busOut(ba), .busValid(va), .holdCount(ha));
  bus_arbiter_2 #(.nrOfBits(8), .maxHold(1), .cntBits(3)) dut_b (
    .clock(clk), .reset(rst), .req_0(r0), .req_1(r1), .muxIn_0(m0), .muxIn_1(m1),
    .grant_0(g0b), .grant_1(g1b), .sel(selb), .enable(enb), .busOut(bb), .busValid(vb), .holdCount(hb));
  function automatic logic [15:0] obs_vec(int k);
    return k == 0 ? {g0a, g1a, sela, ena, va, ba, ha} : {g0b, g1b, selb, enb, vb, bb, hb};
  endfunction
  function automatic logic [15:0] exp_vec(int k);
    int mh = (k == 0) ? 4 : 1;
    int h = (m_ten[k] < mh - 1) ? m_ten[k] : mh - 1;
    return {m_own[k] == 0, m_own[k] == 1, m_own[k] == 1, m_own[k] != -1, m_val[k], m_bus[k], 3'(h)};
  endfunction
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int mh = (k == 0) ? 4 : 1;
      int nxt;
      if (rst) begin
        m_own[k] = -1; m_last[k] = 1; m_ten[k] = 0; m_bus[k] = 0; m_val[k] = 0;
      end else begin
        m_val[k] = (m_own[k] != -1);
        m_bus[k] = (m_own[k] == 1) ? m1 : (m_own[k] == 0) ? m0 : 8'h00;
        if (m_own[k] == -1) nxt = (r0 && r1) ? (m_last[k] == 1 ? 0 : 1) : r0 ? 0 : r1 ? 1 : -1;
        else begin
          logic mine = m_own[k] == 1 ? r1 : r0;
          logic oth = m_own[k] == 1 ? r0 : r1;
          if (!mine) nxt = oth ? 1 - m_own[k] : -1;
          else if (oth && m_ten[k] >= mh - 1) nxt = 1 - m_own[k];
          else nxt = m_own[k];
        end
        m_ten[k] = (nxt == -1 || nxt != m_own[k]) ? 0 : m_ten[k] + 1;
        if (nxt != -1) m_last[k] = nxt;
        m_own[k] = nxt;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1; r0 = 0; r1 = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_bad++; $display("FAIL reset dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    n_cmp++;
    if ({g0a, g1a, ena, va, ba, ha} !== 15'd0) begin
      n_bad++; $display("FAIL reset_zero: got %h want 0", {g0a, g1a, ena, va, ba, ha});
    end
  endtask
  task automatic test_lone_req();
    rst = 1; tick(); rst = 0; r0 = 1; r1 = 0; m0 = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_bad++; $display("FAIL lone dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    n_cmp++;
    if ({g0a, ba, va, ha} !== {1'b1, 8'hA5, 1'b1, 3'd3}) begin
      n_bad++; $display("FAIL lone_sat: got %h want %h", {g0a, ba, va, ha}, {1'b1, 8'hA5, 1'b1, 3'd3});
    end
  endtask
  task automatic test_both_rr();
    logic [15:0] seq_a, seq_b;
    rst = 1; r0 = 0; r1 = 0; tick(); tick(); rst = 0; r0 = 1; r1 = 1;
    for (int i = 0; i < 16; i++) begin
      m0 = 8'($urandom); m1 = 8'($urandom);
      tick();
      seq_a[15-i] = g0a; seq_b[15-i] = g0b;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_bad++; $display("FAIL rr dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    n_cmp++;
    if (seq_a !== 16'hF0F0) begin n_bad++; $display("FAIL rr_seq_hold4: got %h want f0f0", seq_a); end
    n_cmp++;
    if (seq_b !== 16'hAAAA) begin n_bad++; $display("FAIL rr_seq_hold1: got %h want aaaa", seq_b); end
  endtask
  task automatic test_handoff();
    rst = 1; r0 = 0; r1 = 0; tick(); rst = 0; r0 = 1; tick(); r0 = 0; r1 = 1; tick();
    n_cmp++;
    if ({g0a, g1a, ena, ha} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin
      n_bad++; $display("FAIL handoff: got %h want %h", {g0a, g1a, ena, ha}, {1'b0, 1'b1, 1'b1, 3'd0});
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_bad++; $display("FAIL handoff_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask
  task automatic test_reset_mid();
    rst = 1; r0 = 0; r1 = 0; tick(); rst = 0; r1 = 1; tick(); tick(); tick();
    n_cmp++;
    if ({g1a, ha} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL mid_setup: got %h want %h", {g1a, ha}, {1'b1, 3'd2}); end
    rst = 1; tick();
    n_cmp++;
    if ({g0a, g1a, ena, va} !== 4'd0) begin n_bad++; $display("FAIL mid_reset: got %h want 0", {g0a, g1a, ena, va}); end
    rst = 0; r0 = 1; r1 = 1; tick();
    n_cmp++;
    if ({g0a, g1a, g0b, g1b} !== 4'b1010) begin n_bad++; $display("FAIL mid_first: got %b want 1010", {g0a, g1a, g0b, g1b}); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_bad++; $display("FAIL mid_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0);
      m0 = 8'($urandom); m1 = 8'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_bad++; $display("FAIL random dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_last[k] = 1; m_ten[k] = 0; m_bus[k] = 0; m_val[k] = 0;
    end
    test_reset();
    test_lone_req();
    test_both_rr();
    test_handoff();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
